mlp_layer_sequencer: RTL

MLP_LAYER_SEQUENCER -- requirements
Module: mlp_layer_sequencer

---
 rtl/mlp_pkg.sv | 24 ++
 rtl/mlp_layer_sequencer_counter.sv | 55 +++++
 rtl/mlp_layer_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// Shared types and constants for the two-layer MLP sequencer.
package mlp_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_L1_RUN   = 3'd1,
        S_L1_DRAIN = 3'd2,
        S_L2_RUN   = 3'd3,
        S_L2_DRAIN = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam int N_IN_DEF    = 784;
    localparam int N_HID_DEF   = 200;
    localparam int N_OUT_DEF   = 10;
    localparam int MAC_LAT_DEF = 3;

    localparam int ADDR1_W = 18;
    localparam int ADDR2_W = 12;
    localparam int ADDR3_W = 10;
    localparam int HID_W   = 8;
    localparam int RES_W   = 8;

endpackage

// File: rtl/mlp_layer_sequencer_counter.sv
// Nested inner/outer operand counter with a linear address that simply
// increments, so outer*INNER_N+inner never needs a multiplier.
// On the final operand (wrap) the counter returns to zero if advanced; the
// sequencer instead stops advancing there so the last address is held.
module mlp_nested_counter #(
    parameter int INNER_N = 4,
    parameter int OUTER_N = 3,
    parameter int INNER_W = 10,
    parameter int OUTER_W = 8,
    parameter int ADDR_W  = 18
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               clear,
    input  logic               advance,
    output logic [INNER_W-1:0] inner,
    output logic [OUTER_W-1:0] outer,
    output logic [ADDR_W-1:0]  addr,
    output logic               inner_last,
    output logic               wrap
);

    localparam logic [INNER_W-1:0] INNER_MAX = INNER_W'(INNER_N - 1);
    localparam logic [OUTER_W-1:0] OUTER_MAX = OUTER_W'(OUTER_N - 1);

    assign inner_last = (inner == INNER_MAX);
    assign wrap       = inner_last && (outer == OUTER_MAX);

    // Step inner index, carry into outer index, keep linear address in lockstep.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            inner <= '0;
            outer <= '0;
            addr  <= '0;
        end else if (clear) begin
            inner <= '0;
            outer <= '0;
            addr  <= '0;
        end else if (advance) begin
            if (wrap) begin
                inner <= '0;
                outer <= '0;
                addr  <= '0;
            end else if (inner_last) begin
                inner <= '0;
                outer <= outer + OUTER_W'(1);
                addr  <= addr + ADDR_W'(1);
            end else begin
                inner <= inner + INNER_W'(1);
                addr  <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Two-layer MLP inference sequencer: walks layer-1 and layer-2 operand
// addresses, pulses mac_start on each neuron's last operand and issues the
// result write MAC_LAT cycles later through a state-independent delay line.
// Optional feature macro: MLP_SEQ_STALL_EN adds a 'stall' input that freezes
// state, counters and addresses while the result delay line keeps shifting.
//
// state      | meaning
// S_IDLE     | waiting for start, all outputs zero
// S_L1_RUN   | one layer-1 operand per cycle (j inner, i outer)
// S_L1_DRAIN | last layer-1 MAC in flight, addresses held for MAC_LAT cycles
// S_L2_RUN   | one layer-2 operand per cycle (k inner, o outer)
// S_L2_DRAIN | last layer-2 MAC in flight for MAC_LAT cycles
// S_DONE     | one-cycle done pulse, then back to idle
module mlp_layer_sequencer
    import mlp_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int N_HID   = N_HID_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef MLP_SEQ_STALL_EN
    input  logic               stall,
`endif
    output logic               busy,
    output logic               done,
    output logic [ADDR1_W-1:0] address_1,
    output logic [ADDR3_W-1:0] address_3,
    output logic [ADDR2_W-1:0] address_2,
    output logic [HID_W-1:0]   hid_addr,
    output logic               mac_start,
    output logic               layer_sel,
    output logic               res_we,
    output logic [RES_W-1:0]   res_addr
);

    localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_t               state;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 hold;
    logic                 run1, run2, adv1, adv2, clr;

    logic [ADDR3_W-1:0]   cnt_j;
    logic [RES_W-1:0]     cnt_i;
    logic [ADDR1_W-1:0]   cnt_a1;
    logic                 last_j, wrap1;
    logic [HID_W-1:0]     cnt_k;
    logic [RES_W-1:0]     cnt_o;
    logic [ADDR2_W-1:0]   cnt_a2;
    logic                 last_k, wrap2;

    logic [MAC_LAT-1:0]   we_pipe;
    logic [RES_W-1:0]     idx_pipe [MAC_LAT];
    logic [RES_W-1:0]     idx_in;

`ifdef MLP_SEQ_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign run1 = (state == S_L1_RUN);
    assign run2 = (state == S_L2_RUN);
    assign clr  = (state == S_IDLE);
    // The final operand is not advanced past, so drain keeps the last address.
    assign adv1 = run1 && !hold && !wrap1;
    assign adv2 = run2 && !hold && !wrap2;

    mlp_nested_counter #(
        .INNER_N (N_IN),
        .OUTER_N (N_HID),
        .INNER_W (ADDR3_W),
        .OUTER_W (RES_W),
        .ADDR_W  (ADDR1_W)
    ) u_cnt_l1 (
        .clk        (clk),
        .rst_b      (reset),
        .clear      (clr),
        .advance    (adv1),
        .inner      (cnt_j),
        .outer      (cnt_i),
        .addr       (cnt_a1),
        .inner_last (last_j),
        .wrap       (wrap1)
    );

    mlp_nested_counter #(
        .INNER_N (N_HID),
        .OUTER_N (N_OUT),
        .INNER_W (HID_W),
        .OUTER_W (RES_W),
        .ADDR_W  (ADDR2_W)
    ) u_cnt_l2 (
        .clk        (clk),
        .rst_b      (reset),
        .clear      (clr),
        .advance    (adv2),
        .inner      (cnt_k),
        .outer      (cnt_o),
        .addr       (cnt_a2),
        .inner_last (last_k),
        .wrap       (wrap2)
    );

    assign mac_start = !hold && ((run1 && last_j) || (run2 && last_k));

    // Phase sequencing with registered busy/done/layer_sel and drain down-counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            layer_sel <= 1'b0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_L1_RUN;
                        busy  <= 1'b1;
                    end
                end
                S_L1_RUN: begin
                    if (!hold && wrap1) begin
                        state     <= S_L1_DRAIN;
                        drain_cnt <= DRAIN_W'(MAC_LAT - 1);
                    end
                end
                S_L1_DRAIN: begin
                    if (!hold) begin
                        if (drain_cnt == '0) begin
                            state     <= S_L2_RUN;
                            layer_sel <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - DRAIN_W'(1);
                        end
                    end
                end
                S_L2_RUN: begin
                    if (!hold && wrap2) begin
                        state     <= S_L2_DRAIN;
                        drain_cnt <= DRAIN_W'(MAC_LAT - 1);
                    end
                end
                S_L2_DRAIN: begin
                    if (!hold) begin
                        if (drain_cnt == '0) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            layer_sel <= 1'b0;
                        end else begin
                            drain_cnt <= drain_cnt - DRAIN_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    layer_sel <= 1'b0;
                end
            endcase
        end
    end

    // Addresses are only exposed in their own layer, zero elsewhere.
    always_comb begin
        address_1 = '0;
        address_3 = '0;
        address_2 = '0;
        hid_addr  = '0;
        if (state == S_L1_RUN || state == S_L1_DRAIN) begin
            address_1 = cnt_a1;
            address_3 = cnt_j;
        end
        if (state == S_L2_RUN || state == S_L2_DRAIN) begin
            address_2 = cnt_a2;
            hid_addr  = cnt_k;
        end
    end

    assign idx_in = mac_start ? (run2 ? cnt_o : cnt_i) : '0;

    // Result delay line shifts every cycle regardless of state or stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_pipe <= '0;
            for (int s = 0; s < MAC_LAT; s++) idx_pipe[s] <= '0;
        end else begin
            we_pipe[0]  <= mac_start;
            idx_pipe[0] <= idx_in;
            for (int s = 1; s < MAC_LAT; s++) begin
                we_pipe[s]  <= we_pipe[s-1];
                idx_pipe[s] <= idx_pipe[s-1];
            end
        end
    end

    assign res_we   = we_pipe[MAC_LAT-1];
    assign res_addr = idx_pipe[MAC_LAT-1];

endmodule
